// File: rtl/ysyx_22040895_rf_wb_sched_if.sv
// Bundle of issue, source-query, EXU/LSU write-back and regfile write-port signals
// shared by the write-back scheduler (slave) and its surrounding pipeline (master).
interface ysyx_22040895_rf_wb_sched_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  logic            iss_valid_i;
  logic [AW-1:0]   iss_rd_i;
  logic            iss_ready_o;

  logic [AW-1:0]   rs1_i;
  logic [AW-1:0]   rs2_i;
  logic            rs1_busy_o;
  logic            rs2_busy_o;

  logic            exu_valid_i;
  logic [AW-1:0]   exu_rd_i;
  logic [XLEN-1:0] exu_wdata_i;
  logic            exu_ready_o;

  logic            lsu_valid_i;
  logic [AW-1:0]   lsu_rd_i;
  logic [XLEN-1:0] lsu_wdata_i;
  logic            lsu_ready_o;

  logic            rf_we_o;
  logic [AW-1:0]   rf_waddr_o;
  logic [XLEN-1:0] rf_wdata_o;
  logic            idle_o;

  modport slave (
    input  iss_valid_i, iss_rd_i, rs1_i, rs2_i,
    input  exu_valid_i, exu_rd_i, exu_wdata_i,
    input  lsu_valid_i, lsu_rd_i, lsu_wdata_i,
    output iss_ready_o, rs1_busy_o, rs2_busy_o,
    output exu_ready_o, lsu_ready_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o, idle_o
  );

  modport master (
    output iss_valid_i, iss_rd_i, rs1_i, rs2_i,
    output exu_valid_i, exu_rd_i, exu_wdata_i,
    output lsu_valid_i, lsu_rd_i, lsu_wdata_i,
    input  iss_ready_o, rs1_busy_o, rs2_busy_o,
    input  exu_ready_o, lsu_ready_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o, idle_o
  );
endinterface

// File: rtl/ysyx_22040895_rf_wb_sched.sv
// Write-back scheduler + per-GPR pending-write scoreboard for the 32x64 regfile.
// Define YSYX_22040895_WB_RR_EN for round-robin EXU/LSU arbitration; default is fixed LSU > EXU.
module ysyx_22040895_rf_wb_sched #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int PEND_W = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  ysyx_22040895_rf_wb_sched_if.slave   bus
);

  localparam int AW = $clog2(NREG);
  localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

  logic [PEND_W-1:0] cnt_q [NREG];
  logic [PEND_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]   inc_vec;
  logic [NREG-1:0]   dec_vec;
  logic [NREG-1:0]   nz_vec;

  logic            rf_we_q,    rf_we_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  logic            exu_gnt;
  logic            lsu_gnt;
  logic            prio_exu;
  logic            iss_ready;
  logic            iss_fire;

  // ---------------------------------------------------------------------------
  // Arbitration policy
  // ---------------------------------------------------------------------------
`ifdef YSYX_22040895_WB_RR_EN
  // rr_lsu_q = 1 means LSU wins the next contended cycle.
  logic rr_lsu_q, rr_lsu_d;

  assign prio_exu = ~rr_lsu_q;

  always_comb begin
    rr_lsu_d = rr_lsu_q;
    if (bus.exu_valid_i && bus.lsu_valid_i) begin
      rr_lsu_d = exu_gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_lsu_q <= 1'b0;
    end else begin
      rr_lsu_q <= rr_lsu_d;
    end
  end
`else
  assign prio_exu = 1'b0;
`endif

  always_comb begin
    exu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    if (rst) begin
      exu_gnt = bus.exu_valid_i && (!bus.lsu_valid_i || prio_exu);
      lsu_gnt = bus.lsu_valid_i && (!bus.exu_valid_i || !prio_exu);
    end
  end

  assign bus.exu_ready_o = exu_gnt;
  assign bus.lsu_ready_o = lsu_gnt;

  // ---------------------------------------------------------------------------
  // Registered regfile write port; x0 writes are swallowed and leave addr/data held
  // ---------------------------------------------------------------------------
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (exu_gnt && (bus.exu_rd_i != '0)) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = bus.exu_rd_i;
      rf_wdata_d = bus.exu_wdata_i;
    end else if (lsu_gnt && (bus.lsu_rd_i != '0)) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = bus.lsu_rd_i;
      rf_wdata_d = bus.lsu_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign bus.rf_we_o    = rf_we_q;
  assign bus.rf_waddr_o = rf_waddr_q;
  assign bus.rf_wdata_o = rf_wdata_q;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  assign iss_ready = rst && ((bus.iss_rd_i == '0) || (cnt_q[bus.iss_rd_i] != CNT_MAX));
  assign iss_fire  = bus.iss_valid_i && iss_ready;
  assign bus.iss_ready_o = iss_ready;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
      if (gi == 0) begin : g_x0
        assign inc_vec[gi] = 1'b0;
        assign dec_vec[gi] = 1'b0;
      end else begin : g_gpr
        assign inc_vec[gi] = iss_fire && (bus.iss_rd_i == AW'(gi));
        assign dec_vec[gi] = rf_we_q && (rf_waddr_q == AW'(gi));
      end
      assign nz_vec[gi] = (cnt_q[gi] != '0);
    end
  endgenerate

  // Simultaneous set/clear cancels; clearing an idle counter is ignored rather than wrapping.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_vec[i] && !dec_vec[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec_vec[i] && !inc_vec[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.rs1_busy_o = rst && (bus.rs1_i != '0) && nz_vec[bus.rs1_i];
  assign bus.rs2_busy_o = rst && (bus.rs2_i != '0) && nz_vec[bus.rs2_i];
  assign bus.idle_o     = (nz_vec == '0) && !rf_we_q;

endmodule

// File: tb/tb_ysyx_22040895_rf_wb_sched.sv
// Directed bench for the write-back scheduler: reset, single path, contention,
// saturation, same-cycle set/clear, x0 handling and mid-operation reset.
module tb_ysyx_22040895_rf_wb_sched;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  ysyx_22040895_rf_wb_sched_if #(.XLEN(64), .AW(5)) bus ();

  ysyx_22040895_rf_wb_sched #(.XLEN(64), .NREG(32), .PEND_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) begin
      $display("vec %0d %s obs=%h", n_vec, tag, obs);
    end else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.iss_valid_i = 1'b0;
    bus.iss_rd_i    = '0;
    bus.exu_valid_i = 1'b0;
    bus.exu_rd_i    = '0;
    bus.exu_wdata_i = '0;
    bus.lsu_valid_i = 1'b0;
    bus.lsu_rd_i    = '0;
    bus.lsu_wdata_i = '0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    idle_inputs();
    bus.rs1_i = '0;
    bus.rs2_i = '0;

    // 1: reset held 3 cycles with every requester valid
    bus.iss_valid_i = 1'b1; bus.iss_rd_i = 5'd1;
    bus.exu_valid_i = 1'b1; bus.exu_rd_i = 5'd2; bus.exu_wdata_i = 64'h11;
    bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd3; bus.lsu_wdata_i = 64'h22;
    bus.rs1_i = 5'd1;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_iss_ready", bus.iss_ready_o, 1'b0);
    chk("rst_exu_ready", bus.exu_ready_o, 1'b0);
    chk("rst_lsu_ready", bus.lsu_ready_o, 1'b0);
    chk("rst_rf_we", bus.rf_we_o, 1'b0);
    chk("rst_waddr", bus.rf_waddr_o, 5'd0);
    chk("rst_wdata", bus.rf_wdata_o, 64'd0);
    chk("rst_idle", bus.idle_o, 1'b1);
    chk("rst_rs1_busy", bus.rs1_busy_o, 1'b0);
    idle_inputs();
    rst = 1'b1;
    tick();

    // 2: issue rd=5, EXU commits DEAD_BEEF
    bus.iss_valid_i = 1'b1; bus.iss_rd_i = 5'd5; bus.rs1_i = 5'd5;
    #1;
    chk("sp_iss_ready", bus.iss_ready_o, 1'b1);
    tick();
    bus.iss_valid_i = 1'b0;
    chk("sp_rs1_busy_pend", bus.rs1_busy_o, 1'b1);
    chk("sp_idle_pend", bus.idle_o, 1'b0);
    bus.exu_valid_i = 1'b1; bus.exu_rd_i = 5'd5; bus.exu_wdata_i = 64'hDEAD_BEEF;
    #1;
    chk("sp_exu_ready", bus.exu_ready_o, 1'b1);
    chk("sp_lsu_ready", bus.lsu_ready_o, 1'b0);
    tick();
    bus.exu_valid_i = 1'b0;
    chk("sp_rf_we", bus.rf_we_o, 1'b1);
    chk("sp_waddr", bus.rf_waddr_o, 5'd5);
    chk("sp_wdata", bus.rf_wdata_o, 64'hDEAD_BEEF);
    chk("sp_rs1_busy_wr", bus.rs1_busy_o, 1'b1);
    tick();
    chk("sp_rf_we_off", bus.rf_we_o, 1'b0);
    chk("sp_waddr_hold", bus.rf_waddr_o, 5'd5);
    chk("sp_rs1_busy_clr", bus.rs1_busy_o, 1'b0);
    chk("sp_idle", bus.idle_o, 1'b1);

    // 3: contention EXU rd=3 vs LSU rd=4; granted side drops its request
    bus.exu_valid_i = 1'b1; bus.exu_rd_i = 5'd3; bus.exu_wdata_i = 64'hAAAA_0003;
    bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd4; bus.lsu_wdata_i = 64'hBBBB_0004;
    #1;
`ifdef YSYX_22040895_WB_RR_EN
    chk("ct1_exu_ready", bus.exu_ready_o, 1'b1);
    chk("ct1_lsu_ready", bus.lsu_ready_o, 1'b0);
    tick();
    chk("ct1_waddr", bus.rf_waddr_o, 5'd3);
    chk("ct1_wdata", bus.rf_wdata_o, 64'hAAAA_0003);
    bus.exu_valid_i = 1'b0;
    #1;
    chk("ct2_lsu_ready", bus.lsu_ready_o, 1'b1);
    tick();
    chk("ct2_waddr", bus.rf_waddr_o, 5'd4);
    chk("ct2_wdata", bus.rf_wdata_o, 64'hBBBB_0004);
`else
    chk("ct1_lsu_ready", bus.lsu_ready_o, 1'b1);
    chk("ct1_exu_ready", bus.exu_ready_o, 1'b0);
    tick();
    chk("ct1_waddr", bus.rf_waddr_o, 5'd4);
    chk("ct1_wdata", bus.rf_wdata_o, 64'hBBBB_0004);
    bus.lsu_valid_i = 1'b0;
    #1;
    chk("ct2_exu_ready", bus.exu_ready_o, 1'b1);
    tick();
    chk("ct2_waddr", bus.rf_waddr_o, 5'd3);
    chk("ct2_wdata", bus.rf_wdata_o, 64'hAAAA_0003);
`endif
    chk("ct2_rf_we", bus.rf_we_o, 1'b1);
    // Third contention: LSU wins under both policies (fixed priority, or RR pointer now at LSU)
    bus.exu_valid_i = 1'b1; bus.exu_rd_i = 5'd3;
    bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd4;
    #1;
    chk("ct3_lsu_ready", bus.lsu_ready_o, 1'b1);
    chk("ct3_exu_ready", bus.exu_ready_o, 1'b0);
    idle_inputs();
    tick();
    tick();
    chk("ct_idle", bus.idle_o, 1'b1);

    // 4: saturation on rd=7
    bus.iss_valid_i = 1'b1; bus.iss_rd_i = 5'd7; bus.rs1_i = 5'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sat_iss_ready", bus.iss_ready_o, 1'b1);
      tick();
    end
    chk("sat_full", bus.iss_ready_o, 1'b0);
    bus.exu_valid_i = 1'b1; bus.exu_rd_i = 5'd7; bus.exu_wdata_i = 64'h7777;
    #1;
    chk("sat_exu_ready", bus.exu_ready_o, 1'b1);
    tick();
    bus.exu_valid_i = 1'b0;
    chk("sat_rf_we", bus.rf_we_o, 1'b1);
    chk("sat_full_during_we", bus.iss_ready_o, 1'b0);
    tick();
    chk("sat_accept_after", bus.iss_ready_o, 1'b1);
    tick();
    bus.iss_valid_i = 1'b0;
    chk("sat_rs1_busy", bus.rs1_busy_o, 1'b1);
    bus.exu_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.exu_valid_i = 1'b0;
    chk("sat_drain_busy", bus.rs1_busy_o, 1'b1);
    tick();
    chk("sat_drained_busy", bus.rs1_busy_o, 1'b0);
    chk("sat_idle", bus.idle_o, 1'b1);

    // 5: same-cycle set/clear on rd=9
    bus.iss_valid_i = 1'b1; bus.iss_rd_i = 5'd9; bus.rs2_i = 5'd9;
    tick();
    bus.iss_valid_i = 1'b0;
    bus.exu_valid_i = 1'b1; bus.exu_rd_i = 5'd9; bus.exu_wdata_i = 64'h9999;
    tick();
    bus.exu_valid_i = 1'b0;
    bus.iss_valid_i = 1'b1;
    #1;
    chk("sc_rf_we", bus.rf_we_o, 1'b1);
    chk("sc_iss_ready", bus.iss_ready_o, 1'b1);
    tick();
    bus.iss_valid_i = 1'b0;
    chk("sc_rs2_busy", bus.rs2_busy_o, 1'b1);
    chk("sc_idle", bus.idle_o, 1'b0);
    bus.exu_valid_i = 1'b1;
    tick();
    bus.exu_valid_i = 1'b0;
    tick();
    chk("sc_rs2_clr", bus.rs2_busy_o, 1'b0);
    chk("sc_idle_end", bus.idle_o, 1'b1);

    // 6: x0 requests, then mid-operation reset
    bus.exu_valid_i = 1'b1; bus.exu_rd_i = 5'd0; bus.exu_wdata_i = 64'h1234;
    #1;
    chk("x0_exu_ready", bus.exu_ready_o, 1'b1);
    tick();
    bus.exu_valid_i = 1'b0;
    chk("x0_rf_we", bus.rf_we_o, 1'b0);
    chk("x0_waddr_hold", bus.rf_waddr_o, 5'd9);
    bus.iss_valid_i = 1'b1; bus.iss_rd_i = 5'd0;
    #1;
    chk("x0_iss_ready", bus.iss_ready_o, 1'b1);
    tick();
    chk("x0_idle", bus.idle_o, 1'b1);
    bus.iss_rd_i = 5'd2; bus.rs1_i = 5'd2;
    tick();
    bus.iss_valid_i = 1'b0;
    chk("mr_rs1_busy", bus.rs1_busy_o, 1'b1);
    rst = 1'b0;
    #1;
    chk("mr_busy_in_rst", bus.rs1_busy_o, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk("mr_rs1_busy_clr", bus.rs1_busy_o, 1'b0);
    chk("mr_idle", bus.idle_o, 1'b1);
    chk("mr_waddr", bus.rf_waddr_o, 5'd0);
    chk("mr_wdata", bus.rf_wdata_o, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
